// File: rtl/rom_fetch.sv
// ROM prefetch unit: fetches sequential ROM bytes into a small circular queue
// and presents them in address order; a jump flushes the queue and redirects fetch.
module rom_fetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [7:0]  RESET_ADRS = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_adrs,
  output logic       rom_rd,
  input  logic [7:0] rom_dout,
  input  logic       jmp_en,
  input  logic [7:0] jmp_adrs,
  output logic       q_valid,
  output logic [7:0] q_data,
  output logic [7:0] q_adrs,
  input  logic       q_ready
);

  localparam int unsigned AW    = 8;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] adrs;
    logic [AW-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [AW-1:0]      pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  entry_t             head;

  // Fetch/issue decisions; a jump suppresses both push and pop on its edge
  always_comb begin
    q_valid = (count != '0);
    rom_rd  = rst_n & ~jmp_en & (count < CNT_W'(DEPTH));
    push    = rom_rd;
    pop     = q_valid & q_ready & ~jmp_en;
    head    = mem[rd_ptr];
  end

  assign rom_adrs = pc;
  assign q_data   = head.data;
  assign q_adrs   = head.adrs;

  // Queue storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{adrs: pc, data: rom_dout};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_ADRS;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (jmp_en) begin
      pc     <= jmp_adrs;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: queue-level reference model checked every cycle,
// plus directed cycle-exact literal expectations.
module tb_rom_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RST_A = 8'h00;

  logic       clk;
  logic       rst_n;
  logic [7:0] rom_adrs;
  logic       rom_rd;
  logic [7:0] rom_dout;
  logic       jmp_en;
  logic [7:0] jmp_adrs;
  logic       q_valid;
  logic [7:0] q_data;
  logic [7:0] q_adrs;
  logic       q_ready;

  logic [7:0] rom_img [256];

  rom_fetch #(.DEPTH(DEPTH), .RESET_ADRS(RST_A)) dut (
    .clk(clk), .rst_n(rst_n), .rom_adrs(rom_adrs), .rom_rd(rom_rd),
    .rom_dout(rom_dout), .jmp_en(jmp_en), .jmp_adrs(jmp_adrs),
    .q_valid(q_valid), .q_data(q_data), .q_adrs(q_adrs), .q_ready(q_ready)
  );

  assign rom_dout = rom_img[rom_adrs];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  // Directed literal expectation for the current cycle
  logic       lit_on;
  logic       lit_v;
  logic       lit_rd;
  logic [7:0] lit_ra;
  logic       lit_dchk;
  logic [7:0] lit_d;
  logic [7:0] lit_a;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: queue of {adrs,data}; advanced at negedge for the coming edge
  logic [15:0] mq [$];
  logic [7:0]  mpc;
  logic [7:0]  last_pop;
  bit          have_last;

  initial begin
    bit full;
    total = 0;
    bad = 0;
    mpc = RST_A;
    have_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        mpc = RST_A;
        have_last = 0;
      end
      chk("rom_rd", 16'(rom_rd), 16'(rst_n && !jmp_en && (mq.size() < DEPTH)));
      chk("rom_adrs", 16'(rom_adrs), 16'(mpc));
      chk("q_valid", 16'(q_valid), 16'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("q_adrs", 16'(q_adrs), 16'(mq[0][15:8]));
        chk("q_data", 16'(q_data), 16'(mq[0][7:0]));
      end
      if (lit_on) begin
        chk("lit_valid", 16'(q_valid), 16'(lit_v));
        chk("lit_rom_rd", 16'(rom_rd), 16'(lit_rd));
        chk("lit_rom_adrs", 16'(rom_adrs), 16'(lit_ra));
        if (lit_v) chk("lit_q_adrs", 16'(q_adrs), 16'(lit_a));
        if (lit_v && lit_dchk) chk("lit_q_data", 16'(q_data), 16'(lit_d));
      end
      if (rst_n) begin
        if (jmp_en) begin
          mq.delete();
          mpc = jmp_adrs;
          have_last = 0;
        end else begin
          if (q_valid && q_ready) begin
            chk("pop_rom_match", 16'(q_data), 16'(rom_img[q_adrs]));
            if (have_last) chk("pop_contig", 16'(q_adrs), 16'(8'(last_pop + 8'd1)));
            last_pop = q_adrs;
            have_last = 1;
          end
          full = (mq.size() == DEPTH);
          if (mq.size() != 0 && q_ready) void'(mq.pop_front());
          if (!full) begin
            mq.push_back({mpc, rom_img[mpc]});
            mpc = mpc + 8'd1;
          end
        end
      end
    end
  end

  task automatic step(input logic j, input logic [7:0] ja, input logic rdy);
    @(posedge clk);
    #1;
    jmp_en = j;
    jmp_adrs = ja;
    q_ready = rdy;
    lit_on = 1'b0;
  endtask

  task automatic expect_lit(input logic v, input logic rd, input logic [7:0] ra,
                            input logic dchk, input logic [7:0] d, input logic [7:0] a);
    lit_v = v;
    lit_rd = rd;
    lit_ra = ra;
    lit_dchk = dchk;
    lit_d = d;
    lit_a = a;
    lit_on = 1'b1;
  endtask

  initial begin
    logic [7:0] e1 [8];
    logic [7:0] e2 [4];
    logic [7:0] e3 [3];
    e1 = '{8'h01, 8'h02, 8'h05, 8'h22, 8'h01, 8'h03, 8'h0a, 8'h22};
    e2 = '{8'h02, 8'h05, 8'h22, 8'h01};
    e3 = '{8'h03, 8'h0a, 8'h22};
    for (int i = 0; i < 256; i++) rom_img[i] = 8'(i * 37 + 11);
    for (int i = 0; i < 8; i++) rom_img[i] = e1[i];
    rst_n = 1'b0;
    jmp_en = 1'b0;
    jmp_adrs = 8'h00;
    q_ready = 1'b0;
    lit_on = 1'b0;
    lit_v = 1'b0; lit_rd = 1'b0; lit_ra = 8'h00; lit_dchk = 1'b0; lit_d = 8'h00; lit_a = 8'h00;

    // Reset state, then free-running stream with q_ready held high
    step(0, 8'h00, 0); expect_lit(0, 0, 8'h00, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); rst_n = 1'b1; expect_lit(0, 1, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1); expect_lit(1, 1, 8'(i + 1), 1, e1[i], 8'(i));
    end

    // Fill to full with q_ready low, then drain
    step(0, 8'h00, 0); rst_n = 1'b0; expect_lit(0, 0, 8'h00, 0, 8'h00, 8'h00);
    step(0, 8'h00, 0); rst_n = 1'b1; expect_lit(0, 1, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 0); expect_lit(1, (i < 3), 8'(i + 1), 1, 8'h01, 8'h00);
    end
    step(0, 8'h00, 1); expect_lit(1, 0, 8'h04, 1, 8'h01, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1); expect_lit(1, 1, 8'(i + 4), 1, e2[i], 8'(i + 1));
    end

    // Jump to 05 while three bytes are queued and q_ready is high
    step(1, 8'h05, 1); expect_lit(1, 0, 8'h08, 1, 8'h03, 8'h05);
    step(0, 8'h00, 1); expect_lit(0, 1, 8'h05, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1); expect_lit(1, 1, 8'(i + 6), 1, e3[i], 8'(i + 5));
    end

    // Jump to FE: address wrap
    step(1, 8'hFE, 1); expect_lit(1, 0, 8'h09, 0, 8'h00, 8'h08);
    step(0, 8'h00, 1); expect_lit(0, 1, 8'hFE, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); expect_lit(1, 1, 8'hFF, 0, 8'h00, 8'hFE);
    step(0, 8'h00, 1); expect_lit(1, 1, 8'h00, 0, 8'h00, 8'hFF);
    step(0, 8'h00, 1); expect_lit(1, 1, 8'h01, 1, 8'h01, 8'h00);
    step(0, 8'h00, 1); expect_lit(1, 1, 8'h02, 1, 8'h02, 8'h01);

    // Asynchronous reset between edges, mid-stream
    step(0, 8'h00, 1); rst_n = 1'b0; expect_lit(0, 0, 8'h00, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); expect_lit(0, 0, 8'h00, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); rst_n = 1'b1; expect_lit(0, 1, 8'h00, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); expect_lit(1, 1, 8'h01, 1, 8'h01, 8'h00);

    // Back-to-back jumps: last target wins
    step(1, 8'h10, 1); expect_lit(1, 0, 8'h02, 1, 8'h02, 8'h01);
    step(1, 8'h20, 1); expect_lit(0, 0, 8'h10, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); expect_lit(0, 1, 8'h20, 0, 8'h00, 8'h00);
    step(0, 8'h00, 1); expect_lit(1, 1, 8'h21, 0, 8'h00, 8'h20);

    // Random consumer backpressure and jumps
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0));
    end
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
